// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and baud divisor math.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Cycles per bit, truncated toward zero.
  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO for the UART transmitter; zero-latency read data at the head.
// Writes into a full FIFO are ignored; pops from an empty FIFO are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_vld_i,
  input  logic [WIDTH-1:0]         wr_dat_i,
  input  logic                     rd_rdy_i,
  output logic [WIDTH-1:0]         rd_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign full_o   = (cnt_q == CNT_MAX);
  assign empty_o  = (cnt_q == '0);
  assign count_o  = cnt_q;
  assign rd_dat_o = mem_q[rd_ptr_q];

  // Fullness is judged before the pop, so a write into a full FIFO is dropped even on a pop cycle.
  assign do_wr = wr_vld_i && !full_o;
  assign do_rd = rd_rdy_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 framer (8E1 when UART_TX_PARITY_EN is defined).
// Line falls two edges after a write to an idle transmitter; tx_ready drops when the FIFO is full.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_flag,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_ovf,
  output logic       rs232_tx
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);
  localparam int FW = $clog2(FIFO_DEPTH);

  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          line_q, line_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          pop, bit_end;

  logic [7:0]    fifo_dat;
  logic          fifo_full, fifo_empty;
  logic [FW:0]   fifo_cnt;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i    (sclk),
    .rst_ni   (s_rst_n),
    .wr_vld_i (tx_flag),
    .wr_dat_i (tx_data),
    .rd_rdy_i (pop),
    .rd_dat_o (fifo_dat),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_cnt)
  );

  assign tx_ready = !fifo_full;
  assign tx_busy  = busy_q;
  assign tx_ovf   = ovf_q;
  assign rs232_tx = line_q;
  assign bit_end  = (cnt_q == CNT_LAST);

`ifdef UART_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n)  par_q <= 1'b0;
    else if (pop)  par_q <= ^fifo_dat;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    line_d  = STOP_BIT;
    if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dat;
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        line_d = START_BIT;
        if (bit_end) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        line_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        line_d = par_q;
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        line_d = STOP_BIT;
        // A queued byte starts the next frame with no idle bit in between.
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dat;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line and busy are registered from the current state so busy falls as the stop bit ends.
  assign busy_d = (state_q != ST_IDLE) || (fifo_cnt != '0);
  assign ovf_d  = ovf_q || (tx_flag && fifo_full);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      line_q  <= STOP_BIT;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at BAUD_DIV=10: writes push expected frames, a line monitor checks them.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int DIV       = 10;
  localparam int FRAME_CYC = NB * DIV;

  typedef struct packed {
    logic [7:0]  dat;
    logic [10:0] bits;
  } exp_t;

  logic       sclk;
  logic       s_rst_n;
  logic [7:0] tx_data;
  logic       tx_flag;
  logic       tx_ready, tx_busy, tx_ovf, rs232_tx;

  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  exp_t exp_q[$];
  int   start_q[$];

  uart_tx #(
    .CLK_FREQ   (50_000_000),
    .BAUD       (5_000_000),
    .FIFO_DEPTH (16)
  ) dut (
    .sclk     (sclk),
    .s_rst_n  (s_rst_n),
    .tx_data  (tx_data),
    .tx_flag  (tx_flag),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx_ovf   (tx_ovf),
    .rs232_tx (rs232_tx)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  // Line bit k of the frame sits at bits[k].
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f      = '0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
`endif
    return f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic align();
    @(posedge sclk);
    #1;
  endtask

  // Called 1 time unit after an edge; back-to-back calls give a multi-cycle strobe.
  task automatic wr(input logic [7:0] d, input logic [10:0] bits, input bit push, output int c);
    tx_data = d;
    tx_flag = 1'b1;
    if (push) exp_q.push_back('{dat: d, bits: bits});
    @(posedge sclk);
    #1;
    c       = cyc;
    tx_flag = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int drop);
    drop = -1;
    repeat (2) @(posedge sclk);
    for (int i = 0; i < budget; i++) begin
      @(negedge sclk);
      if (!tx_busy) begin
        drop = cyc;
        break;
      end
    end
    if (drop < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", budget);
    end
  endtask

  function automatic int start_at(input int k);
    return (start_q.size() > k) ? start_q[k] : -1;
  endfunction

  // Line monitor: samples every cycle of every frame bit, so bit width and order are both checked.
  initial begin : monitor
    exp_t        e;
    int          bad;
    logic [7:0]  act;
    bit          aborted;
    forever begin
      @(negedge sclk);
      if (s_rst_n && rs232_tx == 1'b0) begin
        start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, expected no frame", cyc);
          repeat (FRAME_CYC - 1) @(negedge sclk);
        end else begin
          e       = exp_q.pop_front();
          bad     = 0;
          act     = '0;
          aborted = 1'b0;
          for (int k = 0; k < FRAME_CYC; k++) begin
            if (k != 0) @(negedge sclk);
            if (!s_rst_n) begin
              aborted = 1'b1;
              break;
            end
            if (rs232_tx !== e.bits[k / DIV]) bad++;
            if ((k % DIV) == 5 && (k / DIV) >= 1 && (k / DIV) <= 8) act[(k / DIV) - 1] = rs232_tx;
          end
          if (!aborted) begin
            vectors++;
            if (bad != 0 || act !== e.dat) begin
              miscompares++;
              $display("FAIL frame: got byte 0x%0h with %0d wrong line cycles, expected byte 0x%0h with 0 wrong",
                       act, bad, e.dat);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(100_000 * 10);
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin : stim
    int c0, cx, drop;
    bit seen;
    s_rst_n = 1'b0;
    tx_flag = 1'b0;
    tx_data = 8'h00;

    repeat (3) @(negedge sclk);
    chk("reset_line",  rs232_tx, 1);
    chk("reset_busy",  tx_busy,  0);
    chk("reset_ready", tx_ready, 1);
    chk("reset_ovf",   tx_ovf,   0);
    #2 s_rst_n = 1'b1;
    repeat (3) @(posedge sclk);

    // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,(parity 0),1.
    start_q.delete();
    align();
`ifdef UART_TX_PARITY_EN
    wr(8'hA5, 11'b10101001010, 1'b1, c0);
`else
    wr(8'hA5, 11'b01101001010, 1'b1, c0);
`endif
    wait_idle(400, drop);
    chk("a5_start_latency", start_at(0), c0 + 2);
    chk("a5_busy_drop",     drop,        c0 + 2 + FRAME_CYC);

    // Three consecutive writes: frames abut with no idle bit.
    start_q.delete();
    align();
    wr(8'h00, frame_of(8'h00), 1'b1, c0);
    wr(8'hFF, frame_of(8'hFF), 1'b1, cx);
    wr(8'h55, frame_of(8'h55), 1'b1, cx);
    wait_idle(800, drop);
    chk("b2b_start0",    start_at(0), c0 + 2);
    chk("b2b_start1",    start_at(1), c0 + 2 + FRAME_CYC);
    chk("b2b_start2",    start_at(2), c0 + 2 + 2 * FRAME_CYC);
    chk("b2b_busy_drop", drop,        c0 + 2 + 3 * FRAME_CYC);

    // 17-byte burst: first byte leaves immediately, 16 fill the FIFO.
    align();
    for (int i = 0; i < 17; i++) begin
      if (i == 16) chk("ready_last_slot", tx_ready, 1);
      wr(8'(i * 13 + 7), frame_of(8'(i * 13 + 7)), 1'b1, cx);
    end
    chk("full_ready", tx_ready, 0);
    chk("full_ovf",   tx_ovf,   0);
    wr(8'hEE, frame_of(8'hEE), 1'b0, cx);
    chk("drop_ovf",   tx_ovf,   1);
    chk("drop_ready", tx_ready, 0);
    wait_idle(18 * FRAME_CYC + 200, drop);
    chk("ovf_sticky", tx_ovf, 1);

    // Reset during data bit 3 of 0x3C while 0x99 waits in the FIFO.
    start_q.delete();
    align();
    wr(8'h3C, frame_of(8'h3C), 1'b1, c0);
    wr(8'h99, frame_of(8'h99), 1'b1, cx);
    for (int i = 0; i < 200; i++) begin
      @(negedge sclk);
      if (cyc >= c0 + 2 + 4 * DIV + 4) break;
    end
    #2 s_rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_line",  rs232_tx, 1);
    chk("midrst_busy",  tx_busy,  0);
    chk("midrst_ready", tx_ready, 1);
    chk("midrst_ovf",   tx_ovf,   0);
    repeat (3) @(negedge sclk);
    #2 s_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      @(negedge sclk);
      if (tx_busy || !rs232_tx) seen = 1'b1;
    end
    chk("midrst_fifo_empty", seen, 0);

    start_q.delete();
    align();
    wr(8'h81, frame_of(8'h81), 1'b1, c0);
    wait_idle(400, drop);
    chk("post_rst_start",     start_at(0), c0 + 2);
    chk("post_rst_busy_drop", drop,        c0 + 2 + FRAME_CYC);

    // Parity vectors: 0x07 (three ones) and 0x03 (two ones).
    start_q.delete();
    align();
`ifdef UART_TX_PARITY_EN
    wr(8'h07, 11'b11000001110, 1'b1, c0);
`else
    wr(8'h07, 11'b01000001110, 1'b1, c0);
`endif
    wait_idle(400, drop);
    chk("x07_frame_len", drop - start_at(0), FRAME_CYC);

    start_q.delete();
    align();
`ifdef UART_TX_PARITY_EN
    wr(8'h03, 11'b10000000110, 1'b1, c0);
`else
    wr(8'h03, 11'b01000000110, 1'b1, c0);
`endif
    wait_idle(400, drop);
    chk("x03_frame_len", drop - start_at(0), FRAME_CYC);

    repeat (5) @(negedge sclk);
    chk("all_frames_seen", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
